alu_sequencer: RTL and testbench
================================

Name: alu_sequencer

Overview:
- Controller that drives the 8-bit ALU: accepts operation requests over a valid/ready handshake and issues ALU operand/opcode/carry-in cycles.
- Captures y/c_out, owns the architectural carry flag, and returns results over a valid/ready response channel.
- Supports 8-bit ops and 16-bit ("wide") ops, which it executes as two chained ALU passes.
- Sits between the processor control/decode logic and the combinational ALU.

Parameters:
- None. Widths are fixed: 8-bit ALU, 16-bit request/response data, 4-bit opcode.

Ports:
- clk  in  1  system clock
- rst_n  in  1  synchronous active-low reset
- req_valid  in  1  request valid
- req_ready  out  1  controller can accept a request
- req_op  in  4  ALU opcode: 0 ADD, 1 SUB, 2 ADC, 3 SBC, 4 AND, 5 OR, 6 NOT, 7 XNOR, 8 ASR, 9 LSL, A LSR, B ROL, C ROR, D RRC
- req_wide  in  1  1 = 16-bit operation
- req_a  in  16  operand A (d0 side)
- req_b  in  16  operand B (d1 side)
- rsp_valid  out  1  response valid
- rsp_ready  in  1  consumer accepts response
- rsp_y  out  16  result; bits [15:8] are 0 for narrow ops
- rsp_c  out  1  carry flag value after the op
- rsp_z  out  1  1 if the full-width result is 0
- rsp_err  out  1  illegal op/width combination
- c_flag  out  1  current carry flag
- alu_d0  out  8  ALU operand 0
- alu_d1  out  8  ALU operand 1
- alu_op  out  4  ALU opcode
- alu_c_in  out  1  ALU carry in
- alu_y  in  8  ALU result (combinational from alu_* outputs)
- alu_c_out  in  1  ALU carry/borrow out

Behaviour:
- One clock (clk); reset is synchronous and active-low (rst_n).
- Reset (rst_n=0 at a clk edge):
  - state returns to IDLE; C flag = 0.
  - rsp_valid, rsp_y, rsp_c, rsp_z, rsp_err = 0.
  - alu_d0, alu_d1, alu_op, alu_c_in = 0.
  - Reset is honoured in any state and discards an in-flight op with no response.
  - req_ready = 0 while rst_n = 0.
- States: IDLE, EXEC0, EXEC1, RESP. req_ready = 1 only in IDLE with rst_n = 1.
- IDLE: on req_valid & req_ready, latch op, wide, a, b.
  - Illegal request (op E/F, or wide with op 8..C) -> go to RESP with rsp_err=1, rsp_y=0, rsp_z=1, rsp_c=C. No ALU cycle; C unchanged.
  - Otherwise go to EXEC0.
- EXEC0/EXEC1: alu_* outputs are registered and stable for the whole state. alu_y/alu_c_out are sampled at the closing edge.
  - Narrow: EXEC0 with op = req_op, bytes a[7:0], b[7:0]. c_in = C for ADC/SBC/RRC, else 0. Then RESP.
  - Wide ADD/SUB: EXEC0 low bytes with ADD/SUB, c_in = 0. EXEC1 high bytes with ADC/SBC, c_in = EXEC0 c_out.
  - Wide ADC/SBC: EXEC0 low bytes with c_in = C. EXEC1 high bytes, same op, c_in = EXEC0 c_out.
  - Wide RRC: EXEC0 high byte, c_in = C. EXEC1 low byte, c_in = EXEC0 c_out. Result = {EXEC0 y, EXEC1 y}.
  - Wide ops 4..7: EXEC0 low bytes, EXEC1 high bytes, same op, c_in = 0.
- C update: for ops 0-3 and D, C is set to the final pass c_out on entry to RESP; other ops leave C unchanged. rsp_c = C after the update. Carry on SUB/SBC is a borrow (1 = borrow).
- RESP: rsp_* stable while rsp_valid=1 and rsp_ready=0. Leave for IDLE at the edge where rsp_ready=1. rsp_valid drops the next cycle.
- Outside EXEC states, alu_* outputs = 0.
- Latency (accept edge to rsp_valid high): narrow 2 cycles, wide 3, error 1. Back-to-back throughput is one op per latency + 1 cycles.

Test Plan:
- Narrow ADD a=0x000A, b=0x0005 -> alu_op=0 for 1 cycle; rsp_y=0x000F, rsp_c=0, rsp_z=0, rsp_valid 2 cycles after accept.
- Wide ADD 0x00FF + 0x0001 -> alu_op sequence 0 then 2, alu_c_in 0 then 1; rsp_y=0x0100, rsp_c=0, latency 3.
- Wide SUB 0x0000 - 0x0001 -> rsp_y=0xFFFF, rsp_c=1. Then narrow SBC 0x00 - 0x01 -> alu_c_in=1; rsp_y=0x00FE, rsp_c=1.
- Wide RRC a=0x00FF with C=1:
  - EXEC0 d0=0x00, c_in=1 -> y=0x80, c_out=0.
  - EXEC1 d0=0xFF, c_in=0 -> y=0x7F, c_out=1.
  - Response: rsp_y=0x807F, rsp_c=1.
- Illegal and backpressure:
  - op=0xE -> rsp_err=1, rsp_y=0, rsp_z=1, C unchanged, latency 1.
  - Wide op=0x9 -> same error response.
  - rsp_ready held 0 for 3 cycles -> rsp stable, req_ready=0.
- Reset mid-op: drop rst_n during EXEC1 of a wide ADD -> next cycle IDLE, req_ready=1, no rsp_valid, c_flag=0, alu_* = 0.

Source files
------------

// File: rtl/alu_sequencer.sv
// Sequencer for the 8-bit combinational ALU. It accepts requests over valid/ready and runs them as one or two ALU passes.
// It owns the architectural carry flag and returns results over a valid/ready response channel.
module alu_sequencer (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        req_valid,
   output logic        req_ready,
   input  logic [3:0]  req_op,
   input  logic        req_wide,
   input  logic [15:0] req_a,
   input  logic [15:0] req_b,
   output logic        rsp_valid,
   input  logic        rsp_ready,
   output logic [15:0] rsp_y,
   output logic        rsp_c,
   output logic        rsp_z,
   output logic        rsp_err,
   output logic        c_flag,
   output logic [7:0]  alu_d0,
   output logic [7:0]  alu_d1,
   output logic [3:0]  alu_op,
   output logic        alu_c_in,
   input  logic [7:0]  alu_y,
   input  logic        alu_c_out
);

   localparam logic [3:0] OP_ADD = 4'h0;
   localparam logic [3:0] OP_SUB = 4'h1;
   localparam logic [3:0] OP_ADC = 4'h2;
   localparam logic [3:0] OP_SBC = 4'h3;
   localparam logic [3:0] OP_RRC = 4'hD;

   typedef enum logic [1:0] {IDLE, EXEC0, EXEC1, RESP} state_t;

   state_t      state, next_state;
   logic [3:0]  op_q;
   logic        wide_q;
   logic [15:0] a_q, b_q;
   logic [7:0]  y_first;

   logic        req_fire, req_illegal, carry_op_q;
   logic [7:0]  p0_d0, p0_d1, p1_d0, p1_d1;
   logic        p0_cin, p1_cin;
   logic [3:0]  p1_op;
   logic [15:0] fin_y;
   logic        fin_c;

   always_ff @(posedge clk) begin
      if (!rst_n) state <= IDLE;
      else        state <= next_state;
   end

   always_comb begin
      next_state  = state;
      req_ready   = rst_n && (state == IDLE);
      req_fire    = req_valid && req_ready;
      req_illegal = (req_op >= 4'hE) || (req_wide && (req_op >= 4'h8) && (req_op <= 4'hC));
      carry_op_q  = (op_q <= OP_SBC) || (op_q == OP_RRC);

      case (state)
         IDLE:    if (req_fire) next_state = req_illegal ? RESP : EXEC0;
         EXEC0:   next_state = wide_q ? EXEC1 : RESP;
         EXEC1:   next_state = RESP;
         RESP:    if (rsp_ready) next_state = IDLE;
         default: next_state = IDLE;
      endcase

      // Wide RRC rotates right, so the high byte goes first and its carry feeds the low byte.
      p0_d0  = (req_wide && req_op == OP_RRC) ? req_a[15:8] : req_a[7:0];
      p0_d1  = (req_wide && req_op == OP_RRC) ? req_b[15:8] : req_b[7:0];
      p0_cin = (req_op inside {OP_ADC, OP_SBC, OP_RRC}) ? c_flag : 1'b0;

      p1_op  = op_q;
      if (op_q == OP_ADD) p1_op = OP_ADC;
      if (op_q == OP_SUB) p1_op = OP_SBC;
      p1_d0  = (op_q == OP_RRC) ? a_q[7:0] : a_q[15:8];
      p1_d1  = (op_q == OP_RRC) ? b_q[7:0] : b_q[15:8];
      p1_cin = carry_op_q ? alu_c_out : 1'b0;

      if (state == EXEC1)
         fin_y = (op_q == OP_RRC) ? {y_first, alu_y} : {alu_y, y_first};
      else
         fin_y = {8'h00, alu_y};
      fin_c = carry_op_q ? alu_c_out : c_flag;
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         op_q      <= 4'h0;
         wide_q    <= 1'b0;
         a_q       <= 16'h0;
         b_q       <= 16'h0;
         y_first   <= 8'h0;
         c_flag    <= 1'b0;
         rsp_valid <= 1'b0;
         rsp_y     <= 16'h0;
         rsp_c     <= 1'b0;
         rsp_z     <= 1'b0;
         rsp_err   <= 1'b0;
         alu_d0    <= 8'h0;
         alu_d1    <= 8'h0;
         alu_op    <= 4'h0;
         alu_c_in  <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (req_fire) begin
                  op_q   <= req_op;
                  wide_q <= req_wide;
                  a_q    <= req_a;
                  b_q    <= req_b;
                  if (req_illegal) begin
                     rsp_valid <= 1'b1;
                     rsp_err   <= 1'b1;
                     rsp_y     <= 16'h0;
                     rsp_z     <= 1'b1;
                     rsp_c     <= c_flag;
                  end else begin
                     alu_op   <= req_op;
                     alu_d0   <= p0_d0;
                     alu_d1   <= p0_d1;
                     alu_c_in <= p0_cin;
                  end
               end
            end
            EXEC0, EXEC1: begin
               if (state == EXEC0 && wide_q) begin
                  y_first  <= alu_y;
                  alu_op   <= p1_op;
                  alu_d0   <= p1_d0;
                  alu_d1   <= p1_d1;
                  alu_c_in <= p1_cin;
               end else begin
                  alu_op    <= 4'h0;
                  alu_d0    <= 8'h0;
                  alu_d1    <= 8'h0;
                  alu_c_in  <= 1'b0;
                  rsp_valid <= 1'b1;
                  rsp_err   <= 1'b0;
                  rsp_y     <= fin_y;
                  rsp_z     <= (fin_y == 16'h0);
                  rsp_c     <= fin_c;
                  c_flag    <= fin_c;
               end
            end
            RESP: begin
               if (rsp_ready) rsp_valid <= 1'b0;
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_alu_sequencer.sv
// Self-checking bench for alu_sequencer. A behavioural ALU drives alu_y/alu_c_out.
// A scoreboard holds expected responses computed with plain 8/16-bit arithmetic.
module tb_alu_sequencer;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        req_valid = 1'b0;
   logic        req_ready;
   logic [3:0]  req_op = 4'h0;
   logic        req_wide = 1'b0;
   logic [15:0] req_a = 16'h0;
   logic [15:0] req_b = 16'h0;
   logic        rsp_valid;
   logic        rsp_ready = 1'b1;
   logic [15:0] rsp_y;
   logic        rsp_c, rsp_z, rsp_err, c_flag;
   logic [7:0]  alu_d0, alu_d1, alu_y;
   logic [3:0]  alu_op;
   logic        alu_c_in, alu_c_out;
   logic [8:0]  alu_t;

   typedef struct {
      logic [15:0] y;
      logic        c;
      logic        z;
      logic        err;
      int          lat;
      int          acc;
   } exp_t;

   exp_t  sb[$];
   int    checks = 0;
   int    fails = 0;
   int    cyc = 0;
   bit    bp_mode = 1'b0;
   bit    hold_low = 1'b0;
   logic  model_c = 1'b0;
   logic  prev_valid = 1'b0;
   logic  prev_ready = 1'b0;
   logic [18:0] prev_rsp = 19'h0;

   alu_sequencer dut (
      .clk(clk), .rst_n(rst_n),
      .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op), .req_wide(req_wide),
      .req_a(req_a), .req_b(req_b),
      .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_y(rsp_y), .rsp_c(rsp_c),
      .rsp_z(rsp_z), .rsp_err(rsp_err), .c_flag(c_flag),
      .alu_d0(alu_d0), .alu_d1(alu_d1), .alu_op(alu_op), .alu_c_in(alu_c_in),
      .alu_y(alu_y), .alu_c_out(alu_c_out)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   // Behavioural 8-bit ALU; SUB/SBC carry is a borrow.
   always_comb begin
      alu_t     = 9'h0;
      alu_y     = 8'h0;
      alu_c_out = 1'b0;
      case (alu_op)
         4'h0: begin alu_t = {1'b0, alu_d0} + {1'b0, alu_d1}; alu_y = alu_t[7:0]; alu_c_out = alu_t[8]; end
         4'h1: begin alu_t = {1'b0, alu_d0} - {1'b0, alu_d1}; alu_y = alu_t[7:0]; alu_c_out = alu_t[8]; end
         4'h2: begin alu_t = {1'b0, alu_d0} + {1'b0, alu_d1} + {8'h0, alu_c_in}; alu_y = alu_t[7:0]; alu_c_out = alu_t[8]; end
         4'h3: begin alu_t = {1'b0, alu_d0} - {1'b0, alu_d1} - {8'h0, alu_c_in}; alu_y = alu_t[7:0]; alu_c_out = alu_t[8]; end
         4'h4: alu_y = alu_d0 & alu_d1;
         4'h5: alu_y = alu_d0 | alu_d1;
         4'h6: alu_y = ~alu_d0;
         4'h7: alu_y = ~(alu_d0 ^ alu_d1);
         4'h8: begin alu_y = {alu_d0[7], alu_d0[7:1]}; alu_c_out = alu_d0[0]; end
         4'h9: begin alu_y = {alu_d0[6:0], 1'b0}; alu_c_out = alu_d0[7]; end
         4'hA: begin alu_y = {1'b0, alu_d0[7:1]}; alu_c_out = alu_d0[0]; end
         4'hB: begin alu_y = {alu_d0[6:0], alu_d0[7]}; alu_c_out = alu_d0[7]; end
         4'hC: begin alu_y = {alu_d0[0], alu_d0[7:1]}; alu_c_out = alu_d0[0]; end
         4'hD: begin alu_y = {alu_c_in, alu_d0[7:1]}; alu_c_out = alu_d0[0]; end
         default: ;
      endcase
   end

   function automatic exp_t refModel(input logic [3:0] op, input logic wide,
                                     input logic [15:0] a, input logic [15:0] b, input logic c);
      exp_t e;
      int   w, mask, ua, ub, r, ci;
      logic nc;
      w    = wide ? 16 : 8;
      mask = (1 << w) - 1;
      ua   = int'(a) & mask;
      ub   = int'(b) & mask;
      ci   = c ? 1 : 0;
      nc   = c;
      r    = 0;
      e.acc = 0;
      e.err = 1'b0;
      e.lat = wide ? 3 : 2;
      if (op >= 4'hE || (wide && op >= 4'h8 && op <= 4'hC)) begin
         e.y = 16'h0; e.c = c; e.z = 1'b1; e.err = 1'b1; e.lat = 1;
         return e;
      end
      case (op)
         4'h0: begin r = ua + ub;      nc = ((r >> w) & 1) != 0; end
         4'h1: begin r = ua - ub;      nc = (ua < ub); end
         4'h2: begin r = ua + ub + ci; nc = ((r >> w) & 1) != 0; end
         4'h3: begin r = ua - ub - ci; nc = (ua < ub + ci); end
         4'h4: r = ua & ub;
         4'h5: r = ua | ub;
         4'h6: r = ~ua;
         4'h7: r = ~(ua ^ ub);
         4'h8: r = (ua >> 1) | (ua & 8'h80);
         4'h9: r = ua << 1;
         4'hA: r = ua >> 1;
         4'hB: r = (ua << 1) | (ua >> 7);
         4'hC: r = (ua >> 1) | ((ua & 1) << 7);
         4'hD: begin r = (ua >> 1) | (ci << (w - 1)); nc = (ua & 1) != 0; end
         default: r = 0;
      endcase
      e.y = 16'(r & mask);
      e.c = nc;
      e.z = (e.y == 16'h0);
      return e;
   endfunction

   task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] expv);
      checks++;
      if (act !== expv) begin
         fails++;
         $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, expv);
      end
   endtask

   task automatic applyStimulus(input logic [3:0] op, input logic wide,
                                input logic [15:0] a, input logic [15:0] b);
      exp_t e;
      int   n;
      @(negedge clk);
      req_valid = 1'b1;
      req_op    = op;
      req_wide  = wide;
      req_a     = a;
      req_b     = b;
      n = 0;
      while (!req_ready && n < 50) begin
         @(negedge clk);
         n++;
      end
      if (!req_ready) begin
         checkOutput("req_ready_timeout", 32'(req_ready), 32'd1);
         req_valid = 1'b0;
         return;
      end
      e       = refModel(op, wide, a, b, model_c);
      e.acc   = cyc;
      model_c = e.c;
      sb.push_back(e);
      @(posedge clk);
      #1;
      req_valid = 1'b0;
   endtask

   task automatic waitDrain();
      int n;
      n = 0;
      while ((sb.size() != 0 || rsp_valid) && n < 200) begin
         @(negedge clk);
         n++;
      end
      if (sb.size() != 0) checkOutput("drain_timeout", 32'(sb.size()), 32'd0);
   endtask

   task automatic checkAlu(input string name, input logic [3:0] op, input logic cin,
                           input logic [7:0] d0, input logic [7:0] d1);
      @(negedge clk);
      checkOutput(name, {11'h0, alu_op, alu_c_in, alu_d0, alu_d1}, {11'h0, op, cin, d0, d1});
   endtask

   // Response ready driver: always ready, random backpressure, or held low.
   initial begin
      forever begin
         @(posedge clk);
         #1;
         if (hold_low)     rsp_ready = 1'b0;
         else if (bp_mode) rsp_ready = 1'($urandom_range(0, 1));
         else              rsp_ready = 1'b1;
      end
   end

   // Monitor: latency on first presentation, stability under backpressure, compare on handshake.
   initial begin
      exp_t e;
      forever begin
         @(negedge clk);
         if (rsp_valid) begin
            if (!prev_valid) begin
               if (sb.size() == 0) checkOutput("unexpected_rsp", 32'(rsp_valid), 32'd0);
               else                checkOutput("latency", 32'(cyc - sb[0].acc), 32'(sb[0].lat));
            end else if (!prev_ready) begin
               checkOutput("rsp_stable", {13'h0, rsp_err, rsp_z, rsp_c, rsp_y}, {13'h0, prev_rsp});
            end
            checkOutput("req_ready_in_resp", 32'(req_ready), 32'd0);
            checkOutput("alu_idle_in_resp", {11'h0, alu_op, alu_c_in, alu_d0, alu_d1}, 32'd0);
            if (rsp_ready && sb.size() != 0) begin
               e = sb.pop_front();
               checkOutput("rsp_err_z_c_y", {13'h0, rsp_err, rsp_z, rsp_c, rsp_y},
                           {13'h0, e.err, e.z, e.c, e.y});
               checkOutput("c_flag", 32'(c_flag), 32'(e.c));
            end
         end
         prev_valid = rsp_valid;
         prev_ready = rsp_ready;
         prev_rsp   = {rsp_err, rsp_z, rsp_c, rsp_y};
      end
   end

   initial begin
      logic [15:0] ra, rb;
      repeat (3) @(negedge clk);
      checkOutput("reset_req_ready", 32'(req_ready), 32'd0);
      checkOutput("reset_rsp", {12'h0, rsp_valid, rsp_err, rsp_z, rsp_c, rsp_y}, 32'd0);
      checkOutput("reset_c_flag", 32'(c_flag), 32'd0);
      checkOutput("reset_alu", {11'h0, alu_op, alu_c_in, alu_d0, alu_d1}, 32'd0);
      @(posedge clk);
      #1 rst_n = 1'b1;

      applyStimulus(4'h0, 1'b0, 16'h000A, 16'h0005);
      checkAlu("narrow_add_pass", 4'h0, 1'b0, 8'h0A, 8'h05);
      waitDrain();

      applyStimulus(4'h0, 1'b1, 16'h00FF, 16'h0001);
      checkAlu("wide_add_pass0", 4'h0, 1'b0, 8'hFF, 8'h01);
      checkAlu("wide_add_pass1", 4'h2, 1'b1, 8'h00, 8'h00);
      waitDrain();

      applyStimulus(4'h1, 1'b1, 16'h0000, 16'h0001);
      waitDrain();
      applyStimulus(4'h3, 1'b0, 16'h0000, 16'h0001);
      checkAlu("narrow_sbc_pass", 4'h3, 1'b1, 8'h00, 8'h01);
      waitDrain();

      applyStimulus(4'hD, 1'b1, 16'h00FF, 16'h0000);
      checkAlu("wide_rrc_pass0", 4'hD, 1'b1, 8'h00, 8'h00);
      checkAlu("wide_rrc_pass1", 4'hD, 1'b0, 8'hFF, 8'h00);
      waitDrain();

      applyStimulus(4'hE, 1'b0, 16'h1234, 16'h5678);
      waitDrain();

      hold_low = 1'b1;
      @(negedge clk);
      applyStimulus(4'h9, 1'b1, 16'h8001, 16'h0003);
      repeat (3) begin
         @(negedge clk);
         checkOutput("bp_req_ready", 32'(req_ready), 32'd0);
         checkOutput("bp_rsp_valid", 32'(rsp_valid), 32'd1);
      end
      hold_low = 1'b0;
      waitDrain();

      bp_mode = 1'b1;
      repeat (150) begin
         rb = 16'($urandom);
         ra = ($urandom_range(0, 3) == 0) ? rb : 16'($urandom);
         applyStimulus(4'($urandom_range(0, 15)), 1'($urandom_range(0, 1)), ra, rb);
         repeat ($urandom_range(0, 2)) @(negedge clk);
      end
      waitDrain();
      bp_mode = 1'b0;

      applyStimulus(4'h1, 1'b1, 16'h0000, 16'h0001);
      waitDrain();
      applyStimulus(4'h0, 1'b1, 16'h1234, 16'h1111);
      @(negedge clk);
      checkAlu("reset_case_pass1", 4'h2, 1'b0, 8'h12, 8'h11);
      rst_n = 1'b0;
      sb.delete();
      model_c = 1'b0;
      @(posedge clk);
      #1 rst_n = 1'b1;
      @(negedge clk);
      checkOutput("midreset_req_ready", 32'(req_ready), 32'd1);
      checkOutput("midreset_c_flag", 32'(c_flag), 32'd0);
      checkOutput("midreset_alu", {11'h0, alu_op, alu_c_in, alu_d0, alu_d1}, 32'd0);
      repeat (3) begin
         checkOutput("midreset_no_rsp", 32'(rsp_valid), 32'd0);
         @(negedge clk);
      end
      applyStimulus(4'h2, 1'b0, 16'h0080, 16'h0080);
      waitDrain();

      $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
      $finish;
   end

endmodule
